ppgen: RTL and testbench
========================

PPGEN -- requirements
Module: ppgen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair on a/b is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts the operand pair this cycle.
REQ-005 SHALL have port a, input, 12 bits: multiplicand, two's complement.
REQ-006 SHALL have port b, input, 12 bits: multiplier, two's complement.
REQ-007 SHALL have port out_valid, output, 1 bit: pp holds a valid partial-product array.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream compressor tree consumes pp this cycle.
REQ-009 SHALL have port pp, output, 144 bits: 12 rows x 12 bits; row i occupies pp[12*i+11 : 12*i], and bit j of row i has weight 2^(i+j).
REQ-010 SHALL have port clr_cnt, input, 1 bit: synchronous clear of zero_cnt.
REQ-011 SHALL have port zero_cnt, output, 16 bits: saturating count of accepted pairs with a==0 or b==0.

Function
REQ-012 SHALL generate Baugh-Wooley rows: row i bit j = a[j]&b[i] for i<11 and j<11.
REQ-013 SHALL generate row i bit 11 = ~(a[11]&b[i]) for i<11, and row 11 bit j = ~(a[j]&b[11]) for j<11.
REQ-014 SHALL generate row 11 bit 11 = a[11]&b[11]; the constant 1s at columns 12 and 23 are not emitted (the consumer adds them).
REQ-015 SHALL accept a transfer when in_valid&&in_ready at a rising edge, and complete a transfer when out_valid&&out_ready at a rising edge.
REQ-016 SHALL drive in_ready = !out_valid || out_ready in the single-stage build (full throughput, one result per cycle).
REQ-017 SHALL, in the single-stage build, assert out_valid after the edge at which the pair is accepted (latency 1).
REQ-018 SHALL hold pp and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL, on a completed output with no simultaneous acceptance, deassert out_valid on the following cycle.
REQ-020 SHALL, on a simultaneous accept and complete, load the new pp and keep out_valid high, with no bubble.
REQ-021 SHALL not depend on a/b values when in_valid is low; the pp register SHALL NOT change.
REQ-022 SHALL increment zero_cnt once per accepted pair with a==12'h000 or b==12'h000, saturating at 16'hFFFF (no wrap).
REQ-023 SHALL give clr_cnt priority over a simultaneous increment: zero_cnt becomes 0.

Reset
REQ-024 SHALL, while rst_n is low, force out_valid=0, pp=0, zero_cnt=0 and all pipeline valid flags to 0, independent of clk.
REQ-025 SHALL drive in_ready=1 during and after reset, because no stage is occupied.
REQ-026 SHALL discard an in-flight result when reset is asserted mid-transfer; it is never presented after reset.

Configuration
REQ-027 SHALL, when macro PPGEN_PIPE2_EN is defined, insert an operand register stage ahead of the pp register, giving latency 2 and capacity 2.
REQ-028 SHALL, with PPGEN_PIPE2_EN, make each stage advance when its successor is empty or draining, with in_ready = !stage1_valid || stage1_can_advance, and sustain one result per cycle under continuous out_ready.
REQ-029 SHALL, without PPGEN_PIPE2_EN, implement only the single pp register stage (REQ-016, REQ-017); port list and zero_cnt behaviour are identical in both builds.

Verification
REQ-030 SHALL cover: a=12'h001, b=12'h001 accepted -> next cycle out_valid=1; pp[0]=1, pp[12*i+11]=1 for i=0..10, pp[142:132]=all 1, pp[143]=0, all other bits 0.
REQ-031 SHALL cover: a=12'h800, b=12'h800 -> pp[143]=1, pp[12*i+11]=1 for i=0..10, pp[142:132]=all 1, all other bits 0; zero_cnt unchanged.
REQ-032 SHALL cover: out_ready=0 for 5 cycles after a result -> pp and out_valid stable, in_ready=0 (single stage), then out_ready=1 -> one transfer, in_ready=1.
REQ-033 SHALL cover: 70000 back-to-back accepted pairs with a=0 -> zero_cnt=16'hFFFF, no wrap; clr_cnt and a zero pair in the same cycle -> zero_cnt=0.
REQ-034 SHALL cover: rst_n low while out_valid=1 and out_ready=0 -> out_valid=0, pp=0 immediately; no stale result after release.
REQ-035 SHALL cover: random a/b streams with random out_ready, in both builds -> the signed sum of all pp bit weights plus 2^12 + 2^23 (mod 2^24) equals a*b (mod 2^24), and results emerge in order with no loss or duplication.

Source files
------------

// File: rtl/ppgen.sv
// ppgen: 12x12 signed Baugh-Wooley partial-product generator with a
// valid/ready handshake and a saturating counter of zero-operand pairs.
//
// Build option:
//    PPGEN_PIPE2_EN  defined   -> operand register stage ahead of the pp
//                                 register (latency 2, capacity 2)
//    PPGEN_PIPE2_EN  undefined -> single pp register stage (latency 1)
//
// The array omits the constant 1s at columns 12 and 23; the downstream
// compressor tree adds them. Port list and zero_cnt behaviour do not
// depend on the build option.

module ppgen (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [11:0]  a,
   input  logic [11:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [143:0] pp,
   input  logic         clr_cnt,
   output logic [15:0]  zero_cnt
);

   localparam int W = 12;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic           accept;
   logic           out_free;
   logic           pp_load;
   logic           zero_pair;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [143:0]   pp_next;

   assign accept    = in_valid && in_ready;
   assign out_free  = !out_valid || out_ready;
   assign zero_pair = (a == '0) || (b == '0);

`ifdef PPGEN_PIPE2_EN
   logic           s1_valid;
   logic [W-1:0]   s1_a;
   logic [W-1:0]   s1_b;

   // Stage 1 drains into the pp register whenever that register is empty
   // or being consumed this cycle; a new pair may enter behind it.
   assign pp_load  = s1_valid && out_free;
   assign in_ready = !s1_valid || out_free;
   assign op_a     = s1_a;
   assign op_b     = s1_b;

   // Operand stage occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (pp_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Operand capture; only an accepted pair is ever loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a <= '0;
         s1_b <= '0;
      end else if (accept) begin
         s1_a <= a;
         s1_b <= b;
      end
   end
`else
   // Single stage: the pp register takes the pair straight from the ports.
   assign pp_load  = accept;
   assign in_ready = out_free;
   assign op_a     = a;
   assign op_b     = b;
`endif

   // Baugh-Wooley array: terms involving exactly one sign bit are inverted,
   // the sign*sign term and the magnitude*magnitude terms are plain ANDs.
   always_comb begin
      pp_next = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            if ((i == W-1) == (j == W-1)) begin
               pp_next[W*i+j] = op_a[j] & op_b[i];
            end else begin
               pp_next[W*i+j] = ~(op_a[j] & op_b[i]);
            end
         end
      end
   end

   // Output register: loads only on a transfer into it, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp <= '0;
      end else if (pp_load) begin
         pp <= pp_next;
      end
   end

   // Output valid: a load wins over a completion so back-to-back results
   // keep out_valid high with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (pp_load) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Zero-operand counter, counted at acceptance; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_cnt <= '0;
      end else if (clr_cnt) begin
         zero_cnt <= '0;
      end else if (accept && zero_pair && (zero_cnt != CNT_MAX)) begin
         zero_cnt <= zero_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ppgen.sv
// tb_ppgen: directed and randomized checks of ppgen. Products are checked
// arithmetically (weighted bit sum vs signed a*b), ordering through a queue
// of expected products, and zero_cnt against a saturating count.

module tb_ppgen;

`ifdef PPGEN_PIPE2_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [11:0]  a;
   logic [11:0]  b;
   logic         out_valid;
   logic         out_ready;
   logic [143:0] pp;
   logic         clr_cnt;
   logic [15:0]  zero_cnt;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int zc_model = 0;

   logic [143:0] exp30;
   logic [143:0] exp31;
   logic [143:0] held_pp;
   int           zc_before;

   ppgen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pp        (pp),
      .clr_cnt   (clr_cnt),
      .zero_cnt  (zero_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Value of the array: sum of bit weights plus the two omitted constants.
   function automatic int pp_value(input logic [143:0] v);
      longint s;
      s = 0;
      for (int i = 0; i < 12; i++)
         for (int j = 0; j < 12; j++)
            if (v[12*i+j]) s += longint'(1) << (i + j);
      s += (longint'(1) << 12) + (longint'(1) << 23);
      return int'(s & 64'hFFFFFF);
   endfunction

   function automatic int product24(input logic [11:0] x, input logic [11:0] y);
      int sx;
      int sy;
      sx = $signed(x);
      sy = $signed(y);
      return (sx * sy) & 32'h00FFFFFF;
   endfunction

   // One cycle, entered just after a falling edge: drive inputs, record the
   // handshakes that the next rising edge performs, then return at the
   // following falling edge.
   task automatic drive(input bit iv, input logic [11:0] av, input logic [11:0] bv,
                        input bit ordy, input bit cc);
      int e;
      in_valid  = iv;
      a         = av;
      b         = bv;
      out_ready = ordy;
      clr_cnt   = cc;
      #1;
      chk("in_ready", in_ready, (exp_q.size() < CAP) || ordy);
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            chk("extra_output", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("product", pp_value(pp), e);
         end
      end
      if (cc) begin
         zc_model = 0;
      end else if (iv && in_ready && (av == 0 || bv == 0) && zc_model < 65535) begin
         zc_model++;
      end
      if (iv && in_ready) exp_q.push_back(product24(av, bv));
      @(negedge clk);
      chk("zero_cnt", zero_cnt, zc_model);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      a = '0; b = '0;

      exp30 = '0;
      exp30[0] = 1'b1;
      for (int i = 0; i < 11; i++) exp30[12*i+11] = 1'b1;
      exp30[142:132] = '1;
      exp31 = '0;
      exp31[143] = 1'b1;
      for (int i = 0; i < 11; i++) exp31[12*i+11] = 1'b1;
      exp31[142:132] = '1;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_pp", pp, '0);
      chk("rst_zero_cnt", zero_cnt, 16'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // 1 x 1, then a 5-cycle stall and a single completion
      drive(1'b1, 12'h001, 12'h001, 1'b0, 1'b0);
      if (CAP == 2) begin
         chk("pipe_not_yet", out_valid, 1'b0);
         drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      end
      chk("one_valid", out_valid, 1'b1);
      chk("one_pp", pp, exp30);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_pp", pp, exp30);
         chk("stall_in_ready", in_ready, (CAP == 2) ? 1'b1 : 1'b0);
      end
      drive(1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
      chk("done_valid", out_valid, 1'b0);
      chk("done_in_ready", in_ready, 1'b1);

      // Most negative x most negative
      zc_before = zc_model;
      drive(1'b1, 12'h800, 12'h800, 1'b0, 1'b0);
      if (CAP == 2) drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      chk("neg_valid", out_valid, 1'b1);
      chk("neg_pp", pp, exp31);
      chk("neg_zero_cnt", zero_cnt, zc_before);
      drive(1'b0, 12'h000, 12'h000, 1'b1, 1'b0);

      // Reset while a result is held
      drive(1'b1, 12'h123, 12'h456, 1'b0, 1'b0);
      if (CAP == 2) drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      chk("pre_rst_valid", out_valid, 1'b1);
      held_pp = pp;
      chk("pre_rst_pp_nonzero", (held_pp != '0), 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_pp", pp, '0);
      chk("async_rst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      zc_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b0);
         chk("post_rst_valid", out_valid, 1'b0);
      end

      // Random streams with random back-pressure
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom % 10) < 7,
               (($urandom % 8) == 0) ? 12'h000 : 12'($urandom),
               (($urandom % 8) == 0) ? 12'h000 : 12'($urandom),
               ($urandom % 10) < 6,
               ($urandom % 64) == 0);
      end
      for (int k = 0; k < 8; k++) drive(1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_valid", out_valid, 1'b0);

      // Saturation of zero_cnt
      drive(1'b0, 12'h000, 12'h000, 1'b1, 1'b1);
      chk("clr_zero_cnt", zero_cnt, 16'h0);
      for (int k = 0; k < 70000; k++) drive(1'b1, 12'h000, 12'($urandom), 1'b1, 1'b0);
      chk("sat_zero_cnt", zero_cnt, 16'hFFFF);
      drive(1'b1, 12'h000, 12'h000, 1'b1, 1'b1);
      chk("clr_priority", zero_cnt, 16'h0);
      for (int k = 0; k < 4; k++) drive(1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
      chk("final_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
